// File: rtl/coproc_pkg.sv
// Shared coprocessor types: pixel/row geometry and the pack FSM states.
package coproc_pkg;
  localparam int PIXEL_WIDTH = 12;
  localparam int IMG_WIDTH   = 256;
  localparam int IMG_HEIGHT  = 256;
  localparam int COL_W       = $clog2(IMG_WIDTH);

  typedef logic [PIXEL_WIDTH-1:0]           pixel_t;
  typedef logic [IMG_WIDTH*PIXEL_WIDTH-1:0] row_t;
  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
endpackage

// File: rtl/pixel_pack_row_bank.sv
// One row buffer: per-slot pixel writes plus a full flag owned by the fill/drain sides.
module row_bank
  import coproc_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [COL_W-1:0] idx,
  input  pixel_t           pixel,
  input  logic             set_full,
  input  logic             clear,
  output row_t             data,
  output logic             full
);
  always_ff @(posedge clk) begin
    if (rst) begin
      data <= '0;
      full <= 1'b0;
    end else begin
      if (we) data[idx*PIXEL_WIDTH +: PIXEL_WIDTH] <= pixel;
      // fill and drain never target the same bank in one cycle
      if (set_full)   full <= 1'b1;
      else if (clear) full <= 1'b0;
    end
  end
endmodule

// File: rtl/pixel_pack.sv
// Packs a raster pixel stream into full rows and writes them out via two ping-pong banks.
module pixel_pack
  import coproc_pkg::*;
#(
  parameter int IMG_HEIGHT = coproc_pkg::IMG_HEIGHT,
  parameter int ROW_AW     = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              pix_valid,
  input  pixel_t            pix_in,
  output logic              pix_ready,
  output logic              wr_req,
  output logic [ROW_AW-1:0] wr_addr,
  output row_t              wr_data,
  input  logic              wr_ack,
  output logic              busy,
  output logic              done
);
  // row counters carry one extra bit so they can reach IMG_HEIGHT
  localparam logic [ROW_AW:0] ROWS     = (ROW_AW+1)'(IMG_HEIGHT);
  localparam logic [ROW_AW:0] LAST_ROW = (ROW_AW+1)'(IMG_HEIGHT-1);
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(IMG_WIDTH-1);

  state_t           state;
  logic [COL_W-1:0] col;
  logic [ROW_AW:0]  row_in, row_out;
  logic             fill_ptr, drain_ptr;
  row_t [1:0]       bank_data;
  logic [1:0]       bank_full, bank_we, bank_set, bank_clr;
  logic             accept, row_done, ack;

  // outputs decode only flops, so they are glitch-free and input-independent
  assign pix_ready = (state == RUN) && !bank_full[fill_ptr] && (row_in < ROWS);
  assign wr_req    = bank_full[drain_ptr];
  assign wr_addr   = row_out[ROW_AW-1:0];
  assign wr_data   = bank_data[drain_ptr];

  assign accept   = pix_valid && pix_ready;
  assign row_done = accept && (col == LAST_COL);
  assign ack      = wr_ack && wr_req;

  for (genvar b = 0; b < 2; b++) begin : g_bank
    assign bank_we[b]  = accept   && (fill_ptr  == 1'(b));
    assign bank_set[b] = row_done && (fill_ptr  == 1'(b));
    assign bank_clr[b] = ack      && (drain_ptr == 1'(b));

    row_bank u_bank (
      .clk     (clk),
      .rst     (rst),
      .we      (bank_we[b]),
      .idx     (col),
      .pixel   (pix_in),
      .set_full(bank_set[b]),
      .clear   (bank_clr[b]),
      .data    (bank_data[b]),
      .full    (bank_full[b])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      col       <= '0;
      row_in    <= '0;
      row_out   <= '0;
      fill_ptr  <= 1'b0;
      drain_ptr <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          state     <= RUN;
          busy      <= 1'b1;
          col       <= '0;
          row_in    <= '0;
          row_out   <= '0;
          fill_ptr  <= 1'b0;
          drain_ptr <= 1'b0;
        end
        RUN: begin
          if (accept) col <= row_done ? '0 : col + 1'b1;
          if (row_done) begin
            row_in   <= row_in + 1'b1;
            fill_ptr <= ~fill_ptr;
          end
          if (ack) begin
            row_out   <= row_out + 1'b1;
            drain_ptr <= ~drain_ptr;
            if (row_out == LAST_ROW) begin
              state <= FIN;
              done  <= 1'b1;
              busy  <= 1'b0;
            end
          end
        end
        FIN:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_pixel_pack.sv
// Directed bench for pixel_pack with a 4-row frame; expected rows come from a pixel generator model.
module tb_pixel_pack;
  import coproc_pkg::*;

  localparam int H = 4;

  logic       clk = 1'b0;
  logic       rst, start, pix_valid, wr_ack;
  pixel_t     pix_in;
  logic       pix_ready, wr_req, busy, done;
  logic [7:0] wr_addr;
  row_t       wr_data;

  int vec  = 0;
  int miss = 0;

  pixel_pack #(.IMG_HEIGHT(H), .ROW_AW(8)) dut (
    .clk(clk), .rst(rst), .start(start), .pix_valid(pix_valid), .pix_in(pix_in),
    .pix_ready(pix_ready), .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_ack(wr_ack), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  function automatic pixel_t pv(input int kind, input int r, input int c);
    case (kind)
      0:       return pixel_t'(r*256 + c);
      1:       return pixel_t'((r*256 + c)*37 + 5);
      default: return pixel_t'(12'h800 | c);
    endcase
  endfunction

  function automatic row_t mk_row(input int kind, input int r);
    row_t e = '0;
    for (int c = 0; c < IMG_WIDTH; c++) e[c*PIXEL_WIDTH +: PIXEL_WIDTH] = pv(kind, r, c);
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_row(input string tag, input row_t exp);
    vec++;
    assert (wr_data === exp) else begin
      miss++;
      $error("FAIL %s: row data observed[31:0] %0h expected[31:0] %0h", tag, wr_data[31:0], exp[31:0]);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // wait (bounded) for pix_ready, then hand over one pixel
  task automatic push(input pixel_t v);
    int t = 0;
    pix_valid = 1'b1;
    pix_in    = v;
    while (!pix_ready && t < 1000) begin tick(); t++; end
    chk("push_ready", pix_ready, 1);
    tick();
    pix_valid = 1'b0;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_pix_ready"}, pix_ready, 0);
    chk({tag, "_wr_req"},    wr_req,    0);
    chk({tag, "_wr_addr"},   wr_addr,   0);
    chk_row({tag, "_wr_data"}, '0);
    chk({tag, "_busy"},      busy,      0);
    chk({tag, "_done"},      done,      0);
  endtask

  initial begin
    int acc_n, wr_n, done_n, wait_c, dly;
    rst = 1'b1; start = 1'b0; pix_valid = 1'b0; pix_in = '0; wr_ack = 1'b0;
    tick(); tick();
    rst = 1'b0;
    chk_reset("reset");

    // pixels and start-less idle are ignored
    pix_valid = 1'b1; pix_in = 12'h123;
    tick(); tick(); tick();
    chk("idle_pix_ready", pix_ready, 0);
    chk("idle_wr_req", wr_req, 0);
    chk("idle_busy", busy, 0);
    pix_valid = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    chk("start_busy", busy, 1);
    chk("start_ready", pix_ready, 1);

    // row 0: wr_req exactly one cycle after the 256th accept
    for (int c = 0; c < 255; c++) push(pv(0, 0, c));
    chk("r0_req_early", wr_req, 0);
    push(pv(0, 0, 255));
    chk("r0_req", wr_req, 1);
    chk("r0_addr", wr_addr, 0);
    chk("r0_first_pix", wr_data[11:0], 12'h000);
    chk("r0_last_pix", wr_data[3071:3060], 12'h0FF);

    // row 1 with ack withheld: both banks fill, stream stalls
    for (int c = 0; c < 256; c++) push(pv(0, 1, c));
    chk("bp_ready", pix_ready, 0);
    chk("bp_addr", wr_addr, 0);
    chk_row("bp_data", mk_row(0, 0));
    tick(); tick();
    chk("bp_hold_addr", wr_addr, 0);
    chk_row("bp_hold_data", mk_row(0, 0));
    wr_ack = 1'b1; tick(); wr_ack = 1'b0;
    chk("bp_ack_req", wr_req, 1);
    chk("bp_ack_addr", wr_addr, 1);
    chk("bp_ack_ready", pix_ready, 1);
    chk_row("bp_ack_data", mk_row(0, 1));

    // row 2 completes in the same cycle row 1 is acked
    for (int c = 0; c < 255; c++) begin
      chk("sim_ready", pix_ready, 1);
      push(pv(0, 2, c));
    end
    wr_ack = 1'b1;
    push(pv(0, 2, 255));
    wr_ack = 1'b0;
    chk("sim_req", wr_req, 1);
    chk("sim_addr", wr_addr, 2);
    chk("sim_ready_after", pix_ready, 1);
    chk_row("sim_data", mk_row(0, 2));

    // last row, then frame end
    for (int c = 0; c < 256; c++) push(pv(0, 3, c));
    chk("end_ready", pix_ready, 0);
    wr_ack = 1'b1; tick(); wr_ack = 1'b0;
    chk("end_addr", wr_addr, 3);
    chk("end_ready_after_ack", pix_ready, 0);
    chk_row("end_data", mk_row(0, 3));
    chk("end_done_early", done, 0);
    wr_ack = 1'b1; tick(); wr_ack = 1'b0;
    chk("end_done", done, 1);
    chk("end_busy", busy, 0);
    chk("end_req", wr_req, 0);
    tick();
    chk("end_done_drop", done, 0);
    wr_ack = 1'b1; tick(); wr_ack = 1'b0;
    chk("stray_ack_req", wr_req, 0);

    // random valid gaps and ack delays
    start = 1'b1; tick(); start = 1'b0;
    acc_n = 0; wr_n = 0; done_n = 0; wait_c = 0;
    dly = $urandom_range(0, 300);
    for (int cyc = 0; cyc < 8000 && wr_n < H; cyc++) begin
      if (done) done_n++;
      wr_ack = 1'b0;
      if (wr_req) begin
        if (wait_c >= dly) begin
          chk("rnd_addr", wr_addr, wr_n);
          chk_row("rnd_data", mk_row(1, wr_n));
          wr_ack = 1'b1;
          wr_n++;
          wait_c = 0;
          dly = $urandom_range(0, 300);
        end else wait_c++;
      end
      pix_valid = ($urandom_range(0, 3) != 0);
      pix_in    = pv(1, acc_n / 256, acc_n % 256);
      if (pix_valid && pix_ready) acc_n++;
      tick();
    end
    wr_ack = 1'b0; pix_valid = 1'b0;
    chk("rnd_writes", wr_n, H);
    chk("rnd_accepts", acc_n, H*256);
    chk("rnd_early_done", done_n, 0);
    chk("rnd_done", done, 1);
    chk("rnd_busy", busy, 0);
    chk("rnd_ready", pix_ready, 0);
    tick();
    chk("rnd_done_drop", done, 0);

    // reset mid-frame at col 100 of row 2
    start = 1'b1; tick(); start = 1'b0;
    wr_ack = 1'b1;
    for (int i = 0; i < 612; i++) push(pv(0, i / 256, i % 256));
    wr_ack = 1'b0;
    rst = 1'b1; tick(); rst = 1'b0;
    chk_reset("midrst");
    start = 1'b1; tick(); start = 1'b0;
    for (int c = 0; c < 256; c++) push(pv(2, 0, c));
    chk("post_rst_req", wr_req, 1);
    chk("post_rst_addr", wr_addr, 0);
    chk_row("post_rst_data", mk_row(2, 0));

    // start while busy is ignored
    start = 1'b1; tick(); start = 1'b0;
    chk("busy_start_req", wr_req, 1);
    chk("busy_start_busy", busy, 1);
    chk_row("busy_start_data", mk_row(2, 0));
    wr_ack = 1'b1; tick(); wr_ack = 1'b0;
    chk("busy_start_row_out", wr_req, 0);
    chk("busy_start_ready", pix_ready, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end
endmodule
